// File: rtl/sub_word_pipe.sv
// AES SubBytes/SubWord engine: source mux + optional RotWord, one input register,
// per-lane S-box, and an optional output register, all under valid/ready flow control.

module sub_word_lane #(
  parameter int INV_EN = 0
) (
  input  logic       inv,
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = xtime(s);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 by square-and-multiply (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^
           {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  endfunction

  logic [7:0] fwd_byte;
  logic [7:0] inv_byte;

  assign fwd_byte = affine(gf_inv(byte_in));

  generate
    if (INV_EN != 0) begin : g_inv
      assign inv_byte = gf_inv(inv_affine(byte_in));
    end else begin : g_no_inv
      assign inv_byte = 8'h00;
    end
  endgenerate

  assign byte_out = (inv && (INV_EN != 0)) ? inv_byte : fwd_byte;
endmodule

module sub_word_pipe #(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 1,
  parameter int INV_EN      = 0,
  parameter int TAG_W       = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_src,
  input  logic                 in_rot,
  input  logic                 in_inv,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [8*LANES-1:0]   col_in,
  input  logic [8*LANES-1:0]   key_a,
  input  logic [8*LANES-1:0]   key_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   sub_out,
  output logic [TAG_W-1:0]     out_tag,
  output logic [1:0]           occupancy
);
  localparam int   DW     = 8 * LANES;
  localparam logic INV_ON = (INV_EN != 0);

  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    s1_word_q, s1_word_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_inv_q, s1_inv_d;

  logic [DW-1:0]    sel_word;
  logic [DW-1:0]    rot_word;
  logic [DW-1:0]    sbox_word;
  logic             s1_leaving;
  logic             accept;

  always_comb begin
    case (in_src)
      2'd1:    sel_word = key_a;
      2'd2:    sel_word = key_b;
      default: sel_word = col_in;
    endcase
  end

  // A one-byte word is its own rotation.
  generate
    if (LANES > 1) begin : g_rot
      assign rot_word = in_rot ? {sel_word[DW-9:0], sel_word[DW-1:DW-8]} : sel_word;
    end else begin : g_no_rot
      assign rot_word = sel_word;
    end
  endgenerate

  assign in_ready = (!s1_valid_q || s1_leaving) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_word_d  = s1_word_q;
    s1_tag_d   = s1_tag_q;
    s1_inv_d   = s1_inv_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      s1_word_d  = rot_word;
      s1_tag_d   = in_tag;
      s1_inv_d   = in_inv && INV_ON;
    end else if (s1_leaving) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
      s1_tag_q   <= '0;
      s1_inv_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_word_q  <= s1_word_d;
      s1_tag_q   <= s1_tag_d;
      s1_inv_q   <= s1_inv_d;
    end
  end

  // Lane 0 is the most significant byte.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sub_word_lane #(.INV_EN(INV_EN)) u_lane (
      .inv      (s1_inv_q),
      .byte_in  (s1_word_q[DW-1-8*i -: 8]),
      .byte_out (sbox_word[DW-1-8*i -: 8])
    );
  end

  generate
    if (PIPE_STAGES >= 2) begin : g_two
      logic             s2_valid_q, s2_valid_d;
      logic [DW-1:0]    s2_word_q, s2_word_d;
      logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
      logic             s2_free;

      assign s2_free    = !s2_valid_q || out_ready;
      assign s1_leaving = s1_valid_q && s2_free;

      always_comb begin
        s2_valid_d = s2_valid_q;
        s2_word_d  = s2_word_q;
        s2_tag_d   = s2_tag_q;
        if (flush) begin
          s2_valid_d = 1'b0;
        end else if (s1_leaving) begin
          s2_valid_d = 1'b1;
          s2_word_d  = sbox_word;
          s2_tag_d   = s1_tag_q;
        end else if (out_ready) begin
          s2_valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s2_valid_q <= 1'b0;
          s2_word_q  <= '0;
          s2_tag_q   <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_word_q  <= s2_word_d;
          s2_tag_q   <= s2_tag_d;
        end
      end

      assign out_valid = s2_valid_q;
      assign sub_out   = s2_word_q;
      assign out_tag   = s2_tag_q;
      assign occupancy = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
    end else begin : g_one
      assign s1_leaving = s1_valid_q && out_ready;
      assign out_valid  = s1_valid_q;
      assign sub_out    = sbox_word;
      assign out_tag    = s1_tag_q;
      assign occupancy  = {1'b0, s1_valid_q};
    end
  endgenerate
endmodule

// File: tb/tb_sub_word_pipe.sv
// Drives a 1-stage forward-only engine and a 2-stage inverse-capable engine from the
// same input bus, each with its own out_ready, against a table-driven AES model.

module tb_sub_word_pipe;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_rot, in_inv;
  logic [1:0]  in_src;
  logic [6:0]  in_tag;
  logic [31:0] col_in, key_a, key_b;
  logic [1:0]  in_ready, out_valid, out_ready;
  logic [31:0] sub_out [2];
  logic [6:0]  out_tag [2];
  logic [1:0]  occ [2];

  always #5 clk = ~clk;

  sub_word_pipe #(.LANES(4), .PIPE_STAGES(1), .INV_EN(0), .TAG_W(7)) u_p1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_src(in_src), .in_rot(in_rot), .in_inv(in_inv), .in_tag(in_tag),
    .col_in(col_in), .key_a(key_a), .key_b(key_b), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sub_out(sub_out[0]), .out_tag(out_tag[0]), .occupancy(occ[0]));

  sub_word_pipe #(.LANES(4), .PIPE_STAGES(2), .INV_EN(1), .TAG_W(7)) u_p2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_src(in_src), .in_rot(in_rot), .in_inv(in_inv), .in_tag(in_tag),
    .col_in(col_in), .key_a(key_a), .key_b(key_b), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sub_out(sub_out[1]), .out_tag(out_tag[1]), .occupancy(occ[1]));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];

  typedef struct {
    logic [31:0] word;
    logic [6:0]  tag;
    int          stamp;
  } exp_t;
  exp_t ring [2][64];
  int head [2];
  int tail [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Classic generator walk: p steps through powers of 3, q through powers of its inverse.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
  endtask

  function automatic logic [31:0] ref_word(input int inv_en);
    logic [31:0] w, r;
    logic [7:0]  b;
    w = (in_src == 2'd1) ? key_a : (in_src == 2'd2) ? key_b : col_in;
    if (in_rot) w = {w[23:0], w[31:24]};
    r = '0;
    for (int i = 0; i < 4; i++) begin
      b = w[31-8*i -: 8];
      r[31-8*i -: 8] = (in_inv && inv_en != 0) ? isbox[b] : sbox[b];
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: index d drives PIPE_STAGES = d+1, INV_EN = d.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      for (int d = 0; d < 2; d++) begin
        int   cnt;
        logic ev;
        exp_t e;
        cnt = tail[d] - head[d];
        ev  = (cnt > 0) && ((cyc - ring[d][head[d] % 64].stamp) >= d + 1);
        chk($sformatf("occ%0d", d), {30'd0, occ[d]}, cnt);
        chk($sformatf("out_valid%0d", d), {31'd0, out_valid[d]}, {31'd0, ev});
        chk($sformatf("in_ready%0d", d), {31'd0, in_ready[d]},
            {31'd0, !flush && (cnt < d + 1 || out_ready[d])});
        if (ev && out_ready[d]) begin
          e = ring[d][head[d] % 64];
          chk($sformatf("sub_out%0d", d), sub_out[d], e.word);
          chk($sformatf("out_tag%0d", d), {25'd0, out_tag[d]}, {25'd0, e.tag});
          head[d]++;
        end
        if (flush) begin
          head[d] = tail[d];
        end else if (in_valid && in_ready[d]) begin
          e.word  = ref_word(d);
          e.tag   = in_tag;
          e.stamp = cyc;
          ring[d][tail[d] % 64] = e;
          tail[d]++;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_v0"}, {31'd0, out_valid[0]}, 32'd0);
    chk({tag, "_v1"}, {31'd0, out_valid[1]}, 32'd0);
    chk({tag, "_occ0"}, {30'd0, occ[0]}, 32'd0);
    chk({tag, "_occ1"}, {30'd0, occ[1]}, 32'd0);
    chk({tag, "_d0"}, sub_out[0], 32'h63636363);
    chk({tag, "_d1"}, sub_out[1], 32'h00000000);
    chk({tag, "_t0"}, {25'd0, out_tag[0]}, 32'd0);
    chk({tag, "_t1"}, {25'd0, out_tag[1]}, 32'd0);
  endtask

  // Entered just after a rising edge with both engines empty.
  task automatic directed(input string tag, input logic [1:0] src, input logic rot,
                          input logic inv, input logic [31:0] col, input logic [31:0] ka,
                          input logic [31:0] kb, input logic [6:0] tg,
                          input logic [31:0] e0, input logic [31:0] e1);
    in_src = src; in_rot = rot; in_inv = inv; col_in = col; key_a = ka; key_b = kb;
    in_tag = tg; in_valid = 1'b1; out_ready = 2'b11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat_v0"}, {31'd0, out_valid[0]}, 32'd1);
    chk({tag, "_lat_d0"}, sub_out[0], e0);
    chk({tag, "_lat_t0"}, {25'd0, out_tag[0]}, {25'd0, tg});
    chk({tag, "_early_v1"}, {31'd0, out_valid[1]}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_lat_v1"}, {31'd0, out_valid[1]}, 32'd1);
    chk({tag, "_lat_d1"}, sub_out[1], e1);
    chk({tag, "_lat_t1"}, {25'd0, out_tag[1]}, {25'd0, tg});
    chk({tag, "_gone_v0"}, {31'd0, out_valid[0]}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    build_tables();
    head = '{0, 0}; tail = '{0, 0};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_src = 2'd0; in_rot = 1'b0;
    in_inv = 1'b0; in_tag = '0; col_in = '0; key_a = '0; key_b = '0; out_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    directed("fwd",   2'd0, 1'b0, 1'b0, 32'h00102030, 32'h0, 32'h0, 7'h15, 32'h63CAB704, 32'h63CAB704);
    directed("rotw",  2'd2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h09CF4F3C, 7'h2A, 32'h8A84EB01, 32'h8A84EB01);
    directed("inv",   2'd0, 1'b0, 1'b1, 32'h63CAB704, 32'h0, 32'h0, 7'h7F, 32'hFB74A9F2, 32'h00102030);
    directed("src3",  2'd3, 1'b0, 1'b0, 32'h00102030, 32'hFFFFFFFF, 32'hFFFFFFFF, 7'h01, 32'h63CAB704, 32'h63CAB704);

    // Two words in flight, then flush.
    out_ready = 2'b00; in_src = 2'd0; in_rot = 1'b0; in_inv = 1'b0;
    in_valid = 1'b1; col_in = $urandom; in_tag = 7'h11;
    @(posedge clk); #1;
    col_in = $urandom; in_tag = 7'h12;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_v0", {31'd0, out_valid[0]}, 32'd0);
    chk("flush_v1", {31'd0, out_valid[1]}, 32'd0);
    chk("flush_occ0", {30'd0, occ[0]}, 32'd0);
    chk("flush_occ1", {30'd0, occ[1]}, 32'd0);
    directed("postflush", 2'd1, 1'b0, 1'b0, 32'h0, 32'h00102030, 32'h0, 7'h33, 32'h63CAB704, 32'h63CAB704);

    // Asynchronous reset with words held.
    out_ready = 2'b00; in_valid = 1'b1; col_in = $urandom; key_a = $urandom;
    @(posedge clk); #1;
    col_in = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    head = '{0, 0}; tail = '{0, 0};
    @(posedge clk); #1;
    reset = 1'b0;

    repeat (600) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_src    = 2'($urandom_range(0, 3));
      in_rot    = 1'($urandom_range(0, 1));
      in_inv    = 1'($urandom_range(0, 1));
      in_tag    = 7'($urandom);
      col_in    = $urandom;
      key_a     = $urandom;
      key_b     = $urandom;
      out_ready = 2'($urandom_range(0, 3));
      flush     = 1'($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 2'b11;
    repeat (5) @(posedge clk);
    #1;
    chk("drain0", tail[0] - head[0], 32'd0);
    chk("drain1", tail[1] - head[1], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
